encoder8x3_serial: RTL and testbench
====================================

# encoder8x3_serial

Sequential 8-to-3 encoder, the inverse of the 3x8 decoder. Eight request lines are captured into a sticky pending register. Each pending request is emitted, one at a time, as a 3-bit index over a valid/ready handshake, and its pending bit is cleared when it is loaded for output. Typical use: serialising decoded one-hot events back into binary codes for a downstream consumer.

## Interface
- RR, default 1 — 1: round-robin selection starting after the last issued index; 0: fixed priority, lowest index wins.
- clk  input  1  — single clock, all state on rising edge.
- rst_n  input  1  — reset, asynchronous assert, active-low.
- i  input  8  — request lines, level-sampled every cycle; multi-hot allowed.
- d  output  3  — encoded index of the request being offered.
- valid  output  1  — d holds a valid index.
- ready  input  1  — consumer accepts d in a cycle where valid && ready.
- pend  output  8  — current pending register, for visibility.
- busy  output  1  — (|pend) || valid.

## Operation
- Registers:
  - pend[7:0]
  - out stage (d, valid)
  - last[2:0], the last issued index
- load = (!valid || ready) && (|pend).
  - When load is asserted, sel = index picked from pend.
  - d <= sel, valid <= 1, last <= sel.
- If (valid && ready && !(|pend)), then valid <= 0 and d holds its old value.
- Pending update every edge: pend <= (pend & ~(load ? onehot(sel) : 0)) | i.
  - A request arriving in the same cycle its bit is cleared re-arms the bit; set wins.
  - The served index is therefore issued again later.
- Selection:
  - RR=1: scan indices last+1, last+2, …, last+8 (mod 8, wrapping 7→0); the first set bit wins.
  - RR=0: the lowest set index wins.
- States: EMPTY (valid=0) and HOLD (valid=1).
  - EMPTY→HOLD on load.
  - HOLD→HOLD when not accepted, or accepted with |pend (back-to-back reload).
  - HOLD→EMPTY when accepted with pend == 0.
- While valid && !ready, d and valid are held stable. pend keeps accumulating. No bit is lost; duplicate requests for an already-pending index merge.
- Width rules: d is 3 bits; the index wrap is natural mod-8 arithmetic on 3 bits.

## Timing
- Reset values: d=3'b000, valid=0, pend=8'h00, busy=0, last=3'd7 (so the first RR scan starts at index 0).
- Reset mid-operation clears all pending and any offered code immediately, asynchronously. Requests present at deassertion are captured on the first rising edge after it.
- Latency:
  - i sampled at edge k sets pend after edge k.
  - If the output stage is free, d/valid are updated after edge k+1.
  - Request to valid is 2 cycles.
- Throughput: one index per cycle while ready=1 and pend is non-empty.
- pend and busy are registered outputs, with no combinational path from i or ready.
- ready is only observed when valid=1.

## Structure
- Package encoder8x3_pkg: N_REQ=8, IDX_W=3, and the function onehot3(idx) returning 8 bits.
- Sub-module rr_pick8 (combinational): inputs pend[7:0], last[2:0], rr; outputs sel[2:0], any. The top level holds all registers and the handshake.

## Test plan
- Reset, then i=8'b0000_0100 for 1 cycle with ready=1 → valid rises 2 cycles later with d=3'd2 for exactly one cycle; pend returns to 0; busy falls after the accept.
- RR=1, i=8'hFF for 1 cycle, ready=1 → d sequence 0,1,2,3,4,5,6,7 on consecutive cycles, then valid=0.
- RR=1, last=3 and i=8'b1000_0101 → order 7, 0, 2 (wrap-around). With RR=0 and the same input → order 0, 2, 7.
- ready=0 while valid with d=5, and i=8'h21 pulsed → d stays 5 and valid stays 1; pend=8'h21 keeps bit 5 re-armed. Raising ready → d=5 accepted, then the next index issues.
- Same-cycle clear and set: hold i[3]=1 continuously, ready=1 → index 3 reissued every cycle with no gaps, pend[3] stays 1.
- Assert rst_n=0 mid-burst (pend=8'hF0, valid=1) → d=0, valid=0, pend=0 immediately, without waiting for a clock edge. After release, no stale index is emitted.

Source files
------------

// File: rtl/encoder8x3_pkg.sv
// Shared sizes, state encoding and index helpers for the serial 8-to-3 encoder.
package encoder8x3_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } enc_state_t;

  function automatic logic [N_REQ-1:0] onehot3(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational picker: round-robin from last+1, or fixed lowest-index priority.
module rr_pick8
  import encoder8x3_pkg::*;
(
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] last,
  input  logic             rr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // The k=8 round-robin candidate wraps onto last itself, so it is considered only
  // after every other index.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = rr ? (last + IDX_W'(k)) : IDX_W'(k - 1);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |pend;

endmodule

// File: rtl/encoder8x3_serial.sv
// Sticky request capture and one-index-per-cycle serialisation over valid/ready.
//   state | meaning
//   EMPTY | no code offered, valid=0
//   HOLD  | d offered, valid=1, held until ready
module encoder8x3_serial
  import encoder8x3_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i,
  output logic [IDX_W-1:0] d,
  output logic             valid,
  input  logic             ready,
  output logic [N_REQ-1:0] pend,
  output logic             busy
);

  enc_state_t       state_q, state_d;
  logic [IDX_W-1:0] d_q;
  logic [IDX_W-1:0] last_q;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             load;

  rr_pick8 u_pick (
    .pend (pend_q),
    .last (last_q),
    .rr   (RR),
    .sel  (sel),
    .any  (any)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (any) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (any) load = 1'b1;
          else     state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Set wins over clear: a request arriving as its bit is served re-arms it.
  always_comb begin
    pend_d = (pend_q & ~(load ? onehot3(sel) : '0)) | i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      d_q     <= '0;
      last_q  <= 3'd7;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (load) begin
        d_q    <= sel;
        last_q <= sel;
      end
    end
  end

  assign d     = d_q;
  assign valid = (state_q == HOLD);
  assign pend  = pend_q;
  assign busy  = (|pend_q) || (state_q == HOLD);

endmodule

// File: tb/tb_encoder8x3_serial.sv
// Directed bench for encoder8x3_serial; round-robin and fixed-priority instances share stimulus.
module tb_encoder8x3_serial;

  logic       clk;
  logic       rst_n;
  logic [7:0] i;
  logic       ready;

  logic [2:0] d1, d0;
  logic       valid1, valid0, busy1, busy0;
  logic [7:0] pend1, pend0;

  int checks   = 0;
  int failures = 0;
  int q1[$];
  int q0[$];

  encoder8x3_serial #(.RR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i(i), .d(d1), .valid(valid1),
    .ready(ready), .pend(pend1), .busy(busy1)
  );

  encoder8x3_serial #(.RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i(i), .d(d0), .valid(valid0),
    .ready(ready), .pend(pend0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted code is popped and compared in issue order.
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (valid1) begin
        chk("sb1_nonempty", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) chk("sb1_d", 32'(d1), 32'(q1.pop_front()));
      end
      if (valid0) begin
        chk("sb0_nonempty", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) chk("sb0_d", 32'(d0), 32'(q0.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i     = 8'h00;
    ready = 1'b1;
    q1.delete();
    q0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy1 || busy0) && n < 30) begin
      step();
      n++;
    end
    chk("drain_idle", 32'({busy1, busy0}), 0);
    chk("sb_empty", 32'(q1.size() + q0.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i     = 8'h00;
    ready = 1'b1;

    // single request, two-cycle latency, one-cycle valid
    do_reset();
    chk("rst_d", 32'(d1), 0);
    chk("rst_valid", 32'(valid1), 0);
    chk("rst_pend", 32'(pend1), 0);
    chk("rst_busy", 32'(busy1), 0);
    i = 8'h04;
    q1.push_back(2);
    q0.push_back(2);
    step();
    i = 8'h00;
    chk("s1_pend_captured", 32'(pend1), 32'h04);
    chk("s1_valid_early", 32'(valid1), 0);
    step();
    chk("s1_valid", 32'(valid1), 1);
    chk("s1_d", 32'(d1), 2);
    chk("s1_pend_cleared", 32'(pend1), 0);
    chk("s1_busy", 32'(busy1), 1);
    step();
    chk("s1_valid_drop", 32'(valid1), 0);
    chk("s1_busy_drop", 32'(busy1), 0);

    // full burst, one index per cycle
    do_reset();
    i = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      q1.push_back(k);
      q0.push_back(k);
    end
    step();
    i = 8'h00;
    chk("s2_pend", 32'(pend1), 32'hFF);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("s2_valid1", 32'(valid1), 1);
      chk("s2_valid0", 32'(valid0), 1);
    end
    step();
    chk("s2_end_valid", 32'({valid1, valid0}), 0);
    drain();

    // wrap-around: set last=3, then request 7,2,0
    do_reset();
    i = 8'h08;
    q1.push_back(3);
    q0.push_back(3);
    step();
    i = 8'h00;
    drain();
    i = 8'h85;
    q1.push_back(7); q1.push_back(0); q1.push_back(2);
    q0.push_back(0); q0.push_back(2); q0.push_back(7);
    step();
    i = 8'h00;
    drain();

    // backpressure holds d while pend accumulates
    do_reset();
    ready = 1'b0;
    i = 8'h20;
    q1.push_back(5);
    q0.push_back(5);
    step();
    i = 8'h00;
    step();
    chk("s4_d", 32'(d1), 5);
    chk("s4_valid", 32'(valid1), 1);
    chk("s4_pend0", 32'(pend1), 0);
    i = 8'h21;
    step();
    i = 8'h00;
    chk("s4_hold_d", 32'(d1), 5);
    chk("s4_hold_pend", 32'(pend1), 32'h21);
    chk("s4_hold_d_fp", 32'(d0), 5);
    step();
    chk("s4_hold2_d", 32'(d1), 5);
    chk("s4_hold2_valid", 32'(valid1), 1);
    chk("s4_hold2_pend", 32'(pend1), 32'h21);
    q1.push_back(0); q1.push_back(5);
    q0.push_back(0); q0.push_back(5);
    ready = 1'b1;
    step();
    chk("s4_next_d", 32'(d1), 0);
    chk("s4_next_pend", 32'(pend1), 32'h20);
    drain();

    // continuous request re-arms its own bit
    do_reset();
    i = 8'h08;
    step();
    chk("s5_pend", 32'(pend1), 32'h08);
    for (int j = 0; j < 6; j++) begin
      step();
      chk("s5_valid", 32'(valid1), 1);
      chk("s5_d", 32'(d1), 3);
      chk("s5_pend_kept", 32'(pend1), 32'h08);
      q1.push_back(3);
      q0.push_back(3);
    end
    i = 8'h00;
    q1.push_back(3);
    q0.push_back(3);
    drain();

    // asynchronous reset mid-burst
    do_reset();
    ready = 1'b0;
    i = 8'hF0;
    step();
    step();
    i = 8'h00;
    chk("s6_pre_pend", 32'(pend1), 32'hF0);
    chk("s6_pre_valid", 32'(valid1), 1);
    chk("s6_pre_d", 32'(d1), 4);
    #3 rst_n = 1'b0;
    #1;
    chk("s6_async_d", 32'(d1), 0);
    chk("s6_async_valid", 32'(valid1), 0);
    chk("s6_async_pend", 32'(pend1), 0);
    chk("s6_async_busy", 32'({busy1, busy0}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("s6_no_stale", 32'({valid1, valid0, busy1, busy0}), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
